// File: rtl/funct_generator_mc.sv
// Multi-channel DDS waveform generator: N_CH channels serviced round-robin,
// one amplitude-scaled sample per cycle into a downstream FIFO with backpressure.
module funct_generator_mc #(
  parameter int N_CH       = 4,
  parameter int DATA_WIDTH = 16,
  parameter int PHASE_W    = 16,
  parameter int LUT_ADDR   = 8,
  parameter int AMP_WIDTH  = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en_i,
  input  logic                         clear_i,
  input  logic                         cfg_we_i,
  input  logic [$clog2(N_CH)-1:0]      cfg_ch_i,
  input  logic [1:0]                   cfg_sel_i,
  input  logic [AMP_WIDTH-1:0]         cfg_amp_i,
  input  logic [PHASE_W-1:0]           cfg_step_i,
  input  logic                         fifo_full_i,
  output logic                         wr_en_o,
  output logic signed [DATA_WIDTH-1:0] data_o,
  output logic [$clog2(N_CH)-1:0]      ch_o,
  output logic                         busy_o
);

  localparam int CH_W      = $clog2(N_CH);
  localparam int LUT_DEPTH = 1 << LUT_ADDR;
  localparam int PROD_W    = DATA_WIDTH + AMP_WIDTH + 1;
  localparam int MAX_INT   = (2 ** (DATA_WIDTH - 1)) - 1;

  localparam logic signed [DATA_WIDTH-1:0] MAX_VAL = DATA_WIDTH'(MAX_INT);
  localparam logic signed [DATA_WIDTH-1:0] MIN_VAL = -MAX_VAL;
  localparam logic signed [PROD_W-1:0]     SAT_HI  = PROD_W'(MAX_INT);
  localparam logic signed [PROD_W-1:0]     SAT_LO  = -SAT_HI;
  localparam logic [LUT_ADDR-1:0]          QUARTER = LUT_ADDR'(LUT_DEPTH / 4);

  typedef enum logic [1:0] {
    IDLE,
    GEN,
    STALL
  } state_t;

  state_t state_q;

  logic [PHASE_W-1:0]   phase_q [N_CH];
  logic [1:0]           sel_q   [N_CH];
  logic [AMP_WIDTH-1:0] amp_q   [N_CH];
  logic [PHASE_W-1:0]   step_q  [N_CH];
  logic [CH_W-1:0]      ptr_q;

  logic                         wr_en_q;
  logic signed [DATA_WIDTH-1:0] data_q;
  logic [CH_W-1:0]              ch_q;

  logic signed [DATA_WIDTH-1:0] lut [LUT_DEPTH];

  // Sine table is a set of elaboration-time constants, rounded half away from zero.
  for (genvar k = 0; k < LUT_DEPTH; k++) begin : g_lut
    localparam real ANGLE  = 2.0 * 3.141592653589793 * real'(k) / real'(LUT_DEPTH);
    localparam real SCALED = real'(MAX_INT) * $sin(ANGLE);
    localparam int  VALUE  = (SCALED >= 0.0) ? $rtoi(SCALED + 0.5) : $rtoi(SCALED - 0.5);
    assign lut[k] = VALUE[DATA_WIDTH-1:0];
  end

  logic                         emit;
  logic [PHASE_W-1:0]           curPhase;
  logic [LUT_ADDR-1:0]          lutAddr;
  logic [LUT_ADDR-1:0]          cosAddr;
  logic [DATA_WIDTH-1:0]        triU;
  logic [DATA_WIDTH:0]          twoQ;
  logic [DATA_WIDTH:0]          maxWide;
  logic [DATA_WIDTH:0]          triWide;
  logic signed [DATA_WIDTH-1:0] wave;
  logic signed [PROD_W-1:0]     waveExt;
  logic signed [PROD_W-1:0]     ampExt;
  logic signed [PROD_W-1:0]     prod;
  logic signed [PROD_W-1:0]     scaled;
  logic signed [DATA_WIDTH-1:0] sample_d;

  assign emit = en_i & ~fifo_full_i & ~clear_i;

  always_comb begin
    curPhase = phase_q[ptr_q];
    lutAddr  = curPhase[PHASE_W-1 -: LUT_ADDR];
    cosAddr  = lutAddr + QUARTER;

    triU    = curPhase[PHASE_W-1 -: DATA_WIDTH];
    twoQ    = {1'b0, triU[DATA_WIDTH-2:0], 1'b0};
    maxWide = {2'b00, {(DATA_WIDTH-1){1'b1}}};
    if (!triU[DATA_WIDTH-1]) begin
      triWide = twoQ - maxWide;
    end else begin
      triWide = maxWide - twoQ;
    end

    case (sel_q[ptr_q])
      2'b00:   wave = lut[lutAddr];
      2'b01:   wave = lut[cosAddr];
      2'b10:   wave = triWide[DATA_WIDTH-1:0];
      default: wave = curPhase[PHASE_W-1] ? MIN_VAL : MAX_VAL;
    endcase

    // Floor-shift back to unity gain, then clamp to the symmetric range.
    waveExt = {{(AMP_WIDTH+1){wave[DATA_WIDTH-1]}}, wave};
    ampExt  = {{(DATA_WIDTH+1){1'b0}}, amp_q[ptr_q]};
    prod    = waveExt * ampExt;
    scaled  = prod >>> (AMP_WIDTH - 1);

    if (scaled > SAT_HI) begin
      sample_d = MAX_VAL;
    end else if (scaled < SAT_LO) begin
      sample_d = MIN_VAL;
    end else begin
      sample_d = scaled[DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wr_en_q <= 1'b0;
      data_q  <= '0;
      ch_q    <= '0;
    end else begin
      wr_en_q <= emit;
      if (clear_i) begin
        data_q <= '0;
        ch_q   <= '0;
      end else if (emit) begin
        data_q <= sample_d;
        ch_q   <= ptr_q;
      end

      if (clear_i) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (en_i) state_q <= GEN;
          end
          GEN: begin
            if (!en_i)            state_q <= IDLE;
            else if (fifo_full_i) state_q <= STALL;
          end
          STALL: begin
            if (!en_i)             state_q <= IDLE;
            else if (!fifo_full_i) state_q <= GEN;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // A config write lands after the emit update so it wins on a same-channel collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        phase_q[i] <= '0;
        sel_q[i]   <= '0;
        amp_q[i]   <= '0;
        step_q[i]  <= '0;
      end
      ptr_q <= '0;
    end else begin
      if (clear_i) begin
        for (int i = 0; i < N_CH; i++) begin
          phase_q[i] <= '0;
        end
        ptr_q <= '0;
      end else if (emit) begin
        phase_q[ptr_q] <= phase_q[ptr_q] + step_q[ptr_q];
        ptr_q          <= ptr_q + CH_W'(1);
      end

      if (cfg_we_i) begin
        sel_q[cfg_ch_i]   <= cfg_sel_i;
        amp_q[cfg_ch_i]   <= cfg_amp_i;
        step_q[cfg_ch_i]  <= cfg_step_i;
        phase_q[cfg_ch_i] <= '0;
      end
    end
  end

  assign wr_en_o = wr_en_q;
  assign data_o  = data_q;
  assign ch_o    = ch_q;
  assign busy_o  = (state_q != IDLE);

endmodule

// File: tb/tb_funct_generator_mc.sv
// Scoreboard bench for funct_generator_mc: directed stimulus pushes expected
// writes into a queue, a negedge monitor pops and compares every FIFO write.
module tb_funct_generator_mc;

  logic        clk;
  logic        rst;
  logic        en_i;
  logic        clear_i;
  logic        cfg_we_i;
  logic [1:0]  cfg_ch_i;
  logic [1:0]  cfg_sel_i;
  logic [7:0]  cfg_amp_i;
  logic [15:0] cfg_step_i;
  logic        fifo_full_i;
  logic        wr_en_o;
  logic signed [15:0] data_o;
  logic [1:0]  ch_o;
  logic        busy_o;

  typedef struct {
    logic [1:0]         ch;
    logic signed [15:0] data;
  } exp_t;

  exp_t expQ[$];
  int   total  = 0;
  int   passed = 0;

  funct_generator_mc dut (
    .clk        (clk),
    .rst        (rst),
    .en_i       (en_i),
    .clear_i    (clear_i),
    .cfg_we_i   (cfg_we_i),
    .cfg_ch_i   (cfg_ch_i),
    .cfg_sel_i  (cfg_sel_i),
    .cfg_amp_i  (cfg_amp_i),
    .cfg_step_i (cfg_step_i),
    .fifo_full_i(fifo_full_i),
    .wr_en_o    (wr_en_o),
    .data_o     (data_o),
    .ch_o       (ch_o),
    .busy_o     (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of control inputs; a predicted write is queued before the edge.
  task automatic applyStimulus(input logic en, input logic full, input logic clr,
                               input logic doPush, input int expCh, input int expData);
    exp_t e;
    en_i        = en;
    fifo_full_i = full;
    clear_i     = clr;
    if (doPush) begin
      e.ch   = 2'(expCh);
      e.data = 16'(expData);
      expQ.push_back(e);
    end
    @(posedge clk);
    #1;
    cfg_we_i = 1'b0;
    clear_i  = 1'b0;
  endtask

  task automatic setCfg(input int ch, input int sel, input int amp, input int step);
    cfg_we_i   = 1'b1;
    cfg_ch_i   = 2'(ch);
    cfg_sel_i  = 2'(sel);
    cfg_amp_i  = 8'(amp);
    cfg_step_i = 16'(step);
  endtask

  task automatic checkOutput(input string name, input logic expWr, input int expData,
                             input int expCh, input logic expBusy);
    total++;
    if (wr_en_o === expWr && data_o === 16'(expData) && ch_o === 2'(expCh) && busy_o === expBusy) begin
      passed++;
    end else begin
      $display("[TB] FAIL %s: got wr=%0b data=%0d ch=%0d busy=%0b, want wr=%0b data=%0d ch=%0d busy=%0b",
               name, wr_en_o, data_o, ch_o, busy_o, expWr, 16'(expData), expCh, expBusy);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && wr_en_o) begin
      total++;
      if (expQ.size() == 0) begin
        $display("[TB] FAIL unexpected_write: got ch=%0d data=%0d, want no write", ch_o, data_o);
      end else begin
        e = expQ.pop_front();
        if (ch_o === e.ch && data_o === e.data) begin
          passed++;
        end else begin
          $display("[TB] FAIL sample: got ch=%0d data=%0d, want ch=%0d data=%0d",
                   ch_o, data_o, e.ch, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    en_i = 1'b0;
    clear_i = 1'b0;
    cfg_we_i = 1'b0;
    cfg_ch_i = '0;
    cfg_sel_i = '0;
    cfg_amp_i = '0;
    cfg_step_i = '0;
    fifo_full_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_state", 1'b0, 0, 0, 1'b0);
    rst = 1'b0;

    // Round-robin with ch0 square at unity gain, other channels silent.
    setCfg(0, 3, 128, 16'h8000);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 1, 0, 32767);
    checkOutput("first_write_busy", 1'b1, 32767, 0, 1'b1);
    applyStimulus(1, 0, 0, 1, 1, 0);
    applyStimulus(1, 0, 0, 1, 2, 0);
    applyStimulus(1, 0, 0, 1, 3, 0);
    applyStimulus(1, 0, 0, 1, 0, -32767);
    applyStimulus(1, 0, 0, 1, 1, 0);
    applyStimulus(1, 0, 0, 1, 2, 0);
    applyStimulus(1, 0, 0, 1, 3, 0);
    applyStimulus(1, 0, 0, 1, 0, 32767);

    // Backpressure holds the last sample and resumes at the next channel.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1, 0, 0, 0, 0);
      checkOutput("stall_hold", 1'b0, 32767, 0, 1'b1);
    end
    applyStimulus(1, 0, 0, 1, 1, 0);
    applyStimulus(1, 0, 0, 1, 2, 0);
    applyStimulus(1, 0, 0, 1, 3, 0);
    applyStimulus(1, 0, 0, 1, 0, -32767);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("disable_idle", 1'b0, -32767, 0, 1'b0);

    // ch1 sine, then reconfigured to cosine on the very edge it is emitted.
    setCfg(1, 0, 128, 16'h4000);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 1, 1, 0);
    applyStimulus(1, 0, 0, 1, 2, 0);
    applyStimulus(1, 0, 0, 1, 3, 0);
    applyStimulus(1, 0, 0, 1, 0, 32767);
    setCfg(1, 1, 128, 16'h0100);
    applyStimulus(1, 0, 0, 1, 1, 32767);
    applyStimulus(1, 0, 0, 1, 2, 0);
    applyStimulus(1, 0, 0, 1, 3, 0);
    applyStimulus(1, 0, 0, 1, 0, -32767);
    applyStimulus(1, 0, 0, 1, 1, 32767);
    applyStimulus(1, 0, 0, 1, 2, 0);
    applyStimulus(1, 0, 0, 1, 3, 0);
    applyStimulus(1, 0, 0, 1, 0, 32767);
    applyStimulus(1, 0, 0, 1, 1, 32757);

    // Clear in the middle of generation restarts at ch0 with zero phases.
    applyStimulus(1, 0, 0, 1, 2, 0);
    applyStimulus(1, 0, 1, 0, 0, 0);
    checkOutput("clear_pulse", 1'b0, 0, 0, 1'b0);
    applyStimulus(1, 0, 0, 1, 0, 32767);
    applyStimulus(1, 0, 0, 1, 1, 32767);
    applyStimulus(1, 0, 0, 1, 2, 0);
    applyStimulus(1, 0, 0, 1, 3, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);

    // Triangle at phase 0 across gains; clear and config share an edge each time.
    setCfg(0, 2, 64, 0);
    applyStimulus(0, 0, 1, 0, 0, 0);
    checkOutput("clear_with_cfg", 1'b0, 0, 0, 1'b0);
    applyStimulus(1, 0, 0, 1, 0, -16384);
    setCfg(0, 2, 128, 0);
    applyStimulus(1, 0, 1, 0, 0, 0);
    applyStimulus(1, 0, 0, 1, 0, -32767);
    setCfg(0, 2, 255, 0);
    applyStimulus(1, 0, 1, 0, 0, 0);
    applyStimulus(1, 0, 0, 1, 0, -32767);

    // Asynchronous reset between edges clears outputs immediately.
    @(negedge clk);
    #2;
    rst  = 1'b1;
    en_i = 1'b0;
    #1;
    checkOutput("async_reset", 1'b0, 0, 0, 1'b0);
    #1;
    rst = 1'b0;
    applyStimulus(1, 0, 0, 1, 0, 0);
    checkOutput("after_reset_ch0", 1'b1, 0, 0, 1'b1);
    applyStimulus(1, 0, 0, 1, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;

    total++;
    if (expQ.size() == 0) begin
      passed++;
    end else begin
      $display("[TB] FAIL missing_writes: got %0d unconsumed expected writes, want 0", expQ.size());
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
